// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx pin between the Z80 CPU byte source and the
// monitor/boot-message byte source. Each frame goes to one requester, chosen
// round-robin when both are waiting, and is sent as 8N1 (or 8N2 with STOP_BITS=2).
// BAUD_DIV is the number of clock cycles per bit and must be in 2..65535.
// STOP_BITS must be 1 or 2.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int BAUD_DIV  = 434,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_data,
  input  logic       cpu_valid,
  output logic       cpu_ready,
  input  logic [7:0] mon_data,
  input  logic       mon_valid,
  output logic       mon_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_owner,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] baud_cnt;
  logic [15:0] baud_next;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_next;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_next;
  logic        owner_next;
  logic        last_grant;
  logic        last_grant_next;
  logic        tx_next;
  logic        baud_wrap;

  assign baud_wrap  = (baud_cnt == BAUD_LAST);
  assign tx_busy    = (state != IDLE);
  assign frame_done = (state == STOP) && baud_wrap && (bit_cnt == STOP_LAST);

  // Grant in IDLE only: a lone requester wins, on contention the one not served last wins.
  always_comb begin
    cpu_ready = 1'b0;
    mon_ready = 1'b0;
    if (state == IDLE) begin
      if (cpu_valid && (!mon_valid || last_grant)) begin
        cpu_ready = 1'b1;
      end else if (mon_valid) begin
        mon_ready = 1'b1;
      end
    end
  end

  // Next-state, counters, shift register and the value uart_tx will take next cycle.
  always_comb begin
    state_next      = state;
    baud_next       = baud_cnt;
    bit_next        = bit_cnt;
    shift_next      = shift_reg;
    owner_next      = tx_owner;
    last_grant_next = last_grant;
    tx_next         = 1'b1;

    case (state)
      IDLE: begin
        baud_next = 16'd0;
        bit_next  = 3'd0;
        if (cpu_ready) begin
          shift_next      = cpu_data;
          owner_next      = 1'b0;
          last_grant_next = 1'b0;
          state_next      = START;
        end else if (mon_ready) begin
          shift_next      = mon_data;
          owner_next      = 1'b1;
          last_grant_next = 1'b1;
          state_next      = START;
        end
      end

      START: begin
        if (baud_wrap) begin
          baud_next  = 16'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        if (baud_wrap) begin
          baud_next = 16'd0;
          if (bit_cnt == 3'd7) begin
            bit_next   = 3'd0;
            state_next = STOP;
          end else begin
            bit_next   = bit_cnt + 3'd1;
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      STOP: begin
        if (baud_wrap) begin
          baud_next = 16'd0;
          if (bit_cnt == STOP_LAST) begin
            bit_next   = 3'd0;
            state_next = IDLE;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
        baud_next  = 16'd0;
        bit_next   = 3'd0;
      end
    endcase

    if (state_next == START) begin
      tx_next = 1'b0;
    end else if (state_next == DATA) begin
      tx_next = shift_next[0];
    end
  end

  // State and datapath registers; uart_tx is registered so the pin never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= 16'd0;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'd0;
      tx_owner   <= 1'b0;
      last_grant <= 1'b1;
      uart_tx    <= 1'b1;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      tx_owner   <= owner_next;
      last_grant <= last_grant_next;
      uart_tx    <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter. dut runs at BAUD_DIV=4 with
// one stop bit (40-cycle frames); dut2 runs at BAUD_DIV=3 with two stop bits.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_data;
  logic       cpu_valid;
  logic       cpu_ready;
  logic [7:0] mon_data;
  logic       mon_valid;
  logic       mon_ready;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_owner;
  logic       frame_done;

  logic [7:0] cpu_data2;
  logic       cpu_valid2;
  logic       cpu_ready2;
  logic [7:0] mon_data2;
  logic       mon_valid2;
  logic       mon_ready2;
  logic       uart_tx2;
  logic       tx_busy2;
  logic       tx_owner2;
  logic       frame_done2;

  int checks = 0;
  int errors = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  uart_tx_arbiter #(.BAUD_DIV(4), .STOP_BITS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_data   (cpu_data),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .mon_data   (mon_data),
    .mon_valid  (mon_valid),
    .mon_ready  (mon_ready),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .tx_owner   (tx_owner),
    .frame_done (frame_done)
  );

  uart_tx_arbiter #(.BAUD_DIV(3), .STOP_BITS(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .cpu_data   (cpu_data2),
    .cpu_valid  (cpu_valid2),
    .cpu_ready  (cpu_ready2),
    .mon_data   (mon_data2),
    .mon_valid  (mon_valid2),
    .mon_ready  (mon_ready2),
    .uart_tx    (uart_tx2),
    .tx_busy    (tx_busy2),
    .tx_owner   (tx_owner2),
    .frame_done (frame_done2)
  );

  // Single-bit comparison point; counts every check and every failure.
  task automatic check_output(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Move to 1 ns after the next rising edge; inputs are driven from here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks frame cycles from_c..to_c (cycle 1 = first cycle after the accept cycle).
  task automatic apply_stimulus_frame(input bit which, input logic [7:0] data, input int div,
                                      input int stops, input int from_c, input int to_c,
                                      input logic owner, input string tag);
    for (int c = from_c; c <= to_c; c++) begin
      logic       exp_tx;
      logic [7:0] sh;
      logic       o_tx;
      logic       o_busy;
      logic       o_done;
      logic       o_owner;
      logic       o_ready;
      step();
      #1;
      if (c <= div) begin
        exp_tx = 1'b0;
      end else if (c <= 9 * div) begin
        sh     = data >> ((c - div - 1) / div);
        exp_tx = sh[0];
      end else begin
        exp_tx = 1'b1;
      end
      o_tx    = which ? uart_tx2 : uart_tx;
      o_busy  = which ? tx_busy2 : tx_busy;
      o_done  = which ? frame_done2 : frame_done;
      o_owner = which ? tx_owner2 : tx_owner;
      o_ready = which ? (cpu_ready2 | mon_ready2) : (cpu_ready | mon_ready);
      check_output($sformatf("%s c%0d uart_tx", tag, c), o_tx, exp_tx);
      check_output($sformatf("%s c%0d tx_busy", tag, c), o_busy, 1'b1);
      check_output($sformatf("%s c%0d frame_done", tag, c), o_done, (c == (9 + stops) * div));
      check_output($sformatf("%s c%0d tx_owner", tag, c), o_owner, owner);
      check_output($sformatf("%s c%0d ready_while_busy", tag, c), o_ready, 1'b0);
    end
  endtask

  // Checks that dut is back in IDLE with the line high.
  task automatic check_idle(input string tag);
    check_output({tag, " idle uart_tx"}, uart_tx, 1'b1);
    check_output({tag, " idle tx_busy"}, tx_busy, 1'b0);
    check_output({tag, " idle frame_done"}, frame_done, 1'b0);
  endtask

  // Runaway guard: the directed sequence needs only a few thousand ns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of all scenarios.
  initial begin
    reset      = 1'b1;
    cpu_data   = 8'h00;
    cpu_valid  = 1'b0;
    mon_data   = 8'h00;
    mon_valid  = 1'b0;
    cpu_data2  = 8'h00;
    cpu_valid2 = 1'b0;
    mon_data2  = 8'h00;
    mon_valid2 = 1'b0;
    #1;
    reset = 1'b0;
    #11;

    // Reset values
    check_output("reset uart_tx", uart_tx, 1'b1);
    check_output("reset tx_busy", tx_busy, 1'b0);
    check_output("reset frame_done", frame_done, 1'b0);
    check_output("reset tx_owner", tx_owner, 1'b0);
    check_output("reset cpu_ready", cpu_ready, 1'b0);
    check_output("reset mon_ready", mon_ready, 1'b0);
    check_output("reset dut2 uart_tx", uart_tx2, 1'b1);
    check_output("reset dut2 tx_busy", tx_busy2, 1'b0);
    step();
    reset = 1'b1;

    // Single cpu byte 0x55
    step();
    cpu_data  = 8'h55;
    cpu_valid = 1'b1;
    #1;
    check_output("t2 cpu_ready", cpu_ready, 1'b1);
    check_output("t2 mon_ready", mon_ready, 1'b0);
    check_idle("t2 accept");
    apply_stimulus_frame(1'b0, 8'h55, 4, 1, 1, 1, 1'b0, "t2");
    cpu_valid = 1'b0;
    cpu_data  = 8'h00;
    apply_stimulus_frame(1'b0, 8'h55, 4, 1, 2, 40, 1'b0, "t2");
    step();
    #1;
    check_idle("t2 after");
    check_output("t2 after cpu_ready", cpu_ready, 1'b0);

    // Busy stall: mon request raised mid-way through a cpu frame
    cpu_data  = 8'h96;
    cpu_valid = 1'b1;
    #1;
    check_output("t4 cpu_ready", cpu_ready, 1'b1);
    apply_stimulus_frame(1'b0, 8'h96, 4, 1, 1, 1, 1'b0, "t4 cpu");
    cpu_valid = 1'b0;
    apply_stimulus_frame(1'b0, 8'h96, 4, 1, 2, 9, 1'b0, "t4 cpu");
    mon_data  = 8'hC3;
    mon_valid = 1'b1;
    apply_stimulus_frame(1'b0, 8'h96, 4, 1, 10, 40, 1'b0, "t4 cpu");
    step();
    #1;
    check_idle("t4 gap");
    check_output("t4 gap mon_ready", mon_ready, 1'b1);
    check_output("t4 gap cpu_ready", cpu_ready, 1'b0);
    apply_stimulus_frame(1'b0, 8'hC3, 4, 1, 1, 1, 1'b1, "t4 mon");
    mon_valid = 1'b0;
    apply_stimulus_frame(1'b0, 8'hC3, 4, 1, 2, 40, 1'b1, "t4 mon");
    step();
    #1;
    check_idle("t4 after");

    // Data change and valid drop one cycle after accept
    cpu_data  = 8'h3C;
    cpu_valid = 1'b1;
    #1;
    check_output("t6 cpu_ready", cpu_ready, 1'b1);
    apply_stimulus_frame(1'b0, 8'h3C, 4, 1, 1, 1, 1'b0, "t6");
    cpu_data  = 8'hE7;
    cpu_valid = 1'b0;
    apply_stimulus_frame(1'b0, 8'h3C, 4, 1, 2, 40, 1'b0, "t6");
    step();
    #1;
    check_idle("t6 after");

    // Reset in the middle of the data bits of 0xA5 (bit 1 is low at cycle 10)
    cpu_data  = 8'hA5;
    cpu_valid = 1'b1;
    #1;
    check_output("t1 cpu_ready", cpu_ready, 1'b1);
    apply_stimulus_frame(1'b0, 8'hA5, 4, 1, 1, 1, 1'b0, "t1");
    cpu_valid = 1'b0;
    apply_stimulus_frame(1'b0, 8'hA5, 4, 1, 2, 10, 1'b0, "t1");
    #1;
    reset = 1'b0;
    #1;
    check_output("t1 async uart_tx", uart_tx, 1'b1);
    check_output("t1 async tx_busy", tx_busy, 1'b0);
    check_output("t1 async frame_done", frame_done, 1'b0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      #1;
      check_idle($sformatf("t1 post c%0d", i));
    end

    // Contention held through reset: cpu wins first, then strict alternation
    reset      = 1'b0;
    cpu_data   = 8'h11;
    mon_data   = 8'h22;
    cpu_valid  = 1'b1;
    mon_valid  = 1'b1;
    #1;
    check_output("t3 in reset cpu_ready", cpu_ready, 1'b1);
    check_output("t3 in reset mon_ready", mon_ready, 1'b0);
    check_idle("t3 in reset");
    step();
    reset = 1'b1;
    #1;
    check_output("t3 first cpu_ready", cpu_ready, 1'b1);
    check_output("t3 first mon_ready", mon_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic       owner;
      logic [7:0] data;
      owner = (k % 2 == 1);
      data  = owner ? 8'h22 : 8'h11;
      apply_stimulus_frame(1'b0, data, 4, 1, 1, 1, owner, $sformatf("t3 f%0d", k));
      if (k == 3) begin
        cpu_valid = 1'b0;
        mon_valid = 1'b0;
      end
      apply_stimulus_frame(1'b0, data, 4, 1, 2, 40, owner, $sformatf("t3 f%0d", k));
      step();
      #1;
      check_idle($sformatf("t3 gap%0d", k));
      check_output($sformatf("t3 gap%0d cpu_ready", k), cpu_ready, (k == 1));
      check_output($sformatf("t3 gap%0d mon_ready", k), mon_ready, (k == 0 || k == 2));
    end

    // STOP_BITS=2, BAUD_DIV=3, byte 0xFF on dut2
    cpu_data2  = 8'hFF;
    cpu_valid2 = 1'b1;
    #1;
    check_output("t5 cpu_ready", cpu_ready2, 1'b1);
    apply_stimulus_frame(1'b1, 8'hFF, 3, 2, 1, 1, 1'b0, "t5");
    cpu_valid2 = 1'b0;
    apply_stimulus_frame(1'b1, 8'hFF, 3, 2, 2, 33, 1'b0, "t5");
    step();
    #1;
    check_output("t5 after tx_busy", tx_busy2, 1'b0);
    check_output("t5 after uart_tx", uart_tx2, 1'b1);
    check_output("t5 after frame_done", frame_done2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
